// File: rtl/dcb_rr_arb_mux.sv
// Round-robin / fixed-priority arbiter feeding one registered output stage with valid/ready.
// The grant vector is also the pop strobe back to each requester queue.

module dcb_rr_arb_lane #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic             grant,
    input  logic             req,
    input  logic             req_q,
    input  logic             grant_q,
    output logic [WIDTH-1:0] data,
    output logic             wd
);
    // One-hot AND-OR mux leg: only the granted lane contributes data.
    assign data = din & {WIDTH{grant}};
    assign wd   = req_q && !grant_q && !req;
endmodule

module dcb_rr_arb_mux #(
    parameter int WIDTH       = 3,
    parameter int CNT         = 6,
    parameter int RR_EN       = 1,
    parameter int PROTO_CHECK = 1,
    parameter int ID_W        = $clog2(CNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT-1:0]       req,
    input  logic [CNT*WIDTH-1:0] din,
    output logic [CNT-1:0]       grant,
    output logic                 dout_vld,
    output logic [WIDTH-1:0]     dout,
    output logic [ID_W-1:0]      dout_id,
    input  logic                 dout_rdy,
    output logic                 err
);
    logic [ID_W-1:0]            ptr;
    logic [ID_W-1:0]            win;
    logic                       found;
    int                         idx;
    logic                       can_acc;
    logic                       accept;
    logic [CNT-1:0]             req_q;
    logic [CNT-1:0]             grant_q;
    logic [CNT-1:0]             wd;
    logic [CNT-1:0][WIDTH-1:0]  lane_data;
    logic [WIDTH-1:0]           sel_data;

    assign can_acc = !dout_vld || dout_rdy;
    assign accept  = can_acc && |req && !rst;

    // RR searches ptr+1, ptr+2, ... mod CNT; fixed priority searches from index 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= CNT; k++) begin
            idx = (RR_EN != 0) ? (int'(ptr) + k) % CNT : k - 1;
            if (!found && req[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign grant = accept ? (CNT'(1) << win) : '0;

    for (genvar i = 0; i < CNT; i++) begin : g_lane
        dcb_rr_arb_lane #(.WIDTH(WIDTH)) u_lane (
            .din     (din[i*WIDTH +: WIDTH]),
            .grant   (grant[i]),
            .req     (req[i]),
            .req_q   (req_q[i]),
            .grant_q (grant_q[i]),
            .data    (lane_data[i]),
            .wd      (wd[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CNT; i++) sel_data = sel_data | lane_data[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld <= 1'b0;
            dout     <= '0;
            dout_id  <= '0;
            ptr      <= ID_W'(CNT - 1);
            req_q    <= '0;
            grant_q  <= '0;
            err      <= 1'b0;
        end else begin
            req_q   <= req;
            grant_q <= grant;
            // A request that disappears without having been granted is a queue protocol bug.
            if (PROTO_CHECK != 0 && |wd) err <= 1'b1;
            if (accept) begin
                dout     <= sel_data;
                dout_id  <= win;
                dout_vld <= 1'b1;
                if (RR_EN != 0) ptr <= win;
            end else if (dout_rdy) begin
                dout_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dcb_rr_arb_mux.sv
// Bench for dcb_rr_arb_mux: vector table plus hand sequences, data/id checked via a scoreboard.

module tb_dcb_rr_arb_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  req = '0;
    logic [17:0] din = '0;
    logic        dout_rdy = 1'b0;

    logic [5:0] grant, grant_fp, grant_np;
    logic       dout_vld, dout_vld_fp, dout_vld_np;
    logic [2:0] dout, dout_fp, dout_np;
    logic [2:0] dout_id, dout_id_fp, dout_id_np;
    logic       err, err_fp, err_np;

    always #5 clk = ~clk;

    dcb_rr_arb_mux #(.WIDTH(3), .CNT(6), .RR_EN(1), .PROTO_CHECK(1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .grant(grant), .dout_vld(dout_vld),
        .dout(dout), .dout_id(dout_id), .dout_rdy(dout_rdy), .err(err));

    dcb_rr_arb_mux #(.WIDTH(3), .CNT(6), .RR_EN(0), .PROTO_CHECK(1)) u_dut_fp (
        .clk(clk), .rst(rst), .req(req), .din(din), .grant(grant_fp), .dout_vld(dout_vld_fp),
        .dout(dout_fp), .dout_id(dout_id_fp), .dout_rdy(dout_rdy), .err(err_fp));

    dcb_rr_arb_mux #(.WIDTH(3), .CNT(6), .RR_EN(1), .PROTO_CHECK(0)) u_dut_np (
        .clk(clk), .rst(rst), .req(req), .din(din), .grant(grant_np), .dout_vld(dout_vld_np),
        .dout(dout_np), .dout_id(dout_id_np), .dout_rdy(dout_rdy), .err(err_np));

    typedef struct {
        logic       do_rst;
        logic [5:0] req;
        logic       rdy;
        logic [5:0] exp_grant;
    } vec_t;

    typedef struct {
        logic [2:0] id;
        logic [2:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic exp_vld = 1'b0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r0, input logic [5:0] r, input logic rdy, input logic [5:0] eg);
        vec_t v;
        v.do_rst = r0; v.req = r; v.rdy = rdy; v.exp_grant = eg;
        vecs.push_back(v);
    endtask

    task automatic do_reset(input logic [5:0] r, input logic rdy);
        @(negedge clk);
        rst = 1'b1; req = r; dout_rdy = rdy;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_grant_fp", grant_fp, 0);
        @(posedge clk);
        #1;
        chk("rst_vld", dout_vld, 0);
        chk("rst_dout", dout, 0);
        chk("rst_id", dout_id, 0);
        chk("rst_err", err, 0);
        chk("rst_err_np", err_np, 0);
        sb.delete();
        exp_vld = 1'b0;
        exp_err = 1'b0;
        rst = 1'b0;
    endtask

    task automatic step(input logic [5:0] r, input logic rdy, input logic [5:0] eg);
        logic [5:0] efp;
        exp_t       e;
        int         gi;
        @(negedge clk);
        req = r; dout_rdy = rdy; din = 18'($urandom);
        #1;
        efp = (eg != 0) ? (r & (~r + 6'd1)) : 6'd0;
        chk("grant", grant, eg);
        chk("grant_fp", grant_fp, efp);
        if (exp_vld && rdy && sb.size() > 0) void'(sb.pop_front());
        if (eg != 0) begin
            gi = 0;
            for (int i = 0; i < 6; i++) if (eg[i]) gi = i;
            e.id = 3'(gi);
            e.data = din[gi*3 +: 3];
            sb.push_back(e);
            exp_vld = 1'b1;
        end else if (rdy) begin
            exp_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("dout_vld", dout_vld, exp_vld);
        if (exp_vld) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: got empty queue want entry (t=%0t)", $time);
            end else begin
                chk("dout_id", dout_id, sb[0].id);
                chk("dout", dout, sb[0].data);
            end
        end
        chk("err", err, exp_err);
        chk("err_np", err_np, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset with all requesting, then a two-lap round-robin sweep.
        add(1, 6'h3F, 1, 6'h01);
        for (int i = 1; i < 12; i++) add(0, 6'h3F, 1, 6'(1 << (i % 6)));
        // Move ptr to 1, stall the output, release, then wrap and 6'h30 patterns.
        add(1, 6'h03, 1, 6'h01);
        add(0, 6'h02, 1, 6'h02);
        for (int i = 0; i < 4; i++) add(0, 6'h24, 0, 6'h00);
        add(0, 6'h24, 1, 6'h04);
        add(0, 6'h20, 1, 6'h20);
        add(0, 6'h21, 1, 6'h01);
        add(0, 6'h30, 1, 6'h10);
        add(0, 6'h30, 1, 6'h20);
        add(0, 6'h30, 1, 6'h10);
        add(0, 6'h30, 1, 6'h20);
        add(0, 6'h10, 1, 6'h10);
        add(0, 6'h00, 1, 6'h00);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset(vecs[i].req, 1'b1);
            step(vecs[i].req, vecs[i].rdy, vecs[i].exp_grant);
        end

        // Request 3 withdrawn while the output is stalled.
        step(6'h01, 1, 6'h01);
        step(6'h08, 0, 6'h00);
        step(6'h08, 0, 6'h00);
        exp_err = 1'b1;
        step(6'h00, 0, 6'h00);
        step(6'h00, 1, 6'h00);
        step(6'h3F, 1, 6'h02);
        step(6'h3F, 1, 6'h04);

        // Reset while holding a stalled beat.
        step(6'h3F, 0, 6'h00);
        do_reset(6'h3F, 1'b0);
        step(6'h3F, 1, 6'h01);
        step(6'h3F, 1, 6'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
